// File: rtl/dac_jesd_tx_framer.sv
// Two-channel DAC transmit framer: 4-deep DMA FIFO, ramp/zero test patterns, 2-lane JESD transport word.
// Optional PN15 generator built only when DAC_TX_PN_GEN_EN is defined; otherwise pattern_sel=3 sends zeros.
module dac_jesd_tx_framer #(
    parameter int DATA_FORMAT_OB = 0
) (
    input  logic        tx_clk,
    input  logic        tx_rstn,
    input  logic        dac_enable_a,
    input  logic        dac_enable_b,
    input  logic        dac_valid,
    input  logic [31:0] dac_data_a,
    input  logic [31:0] dac_data_b,
    output logic        dac_ready,
    input  logic [1:0]  pattern_sel,
    input  logic        cnt_clr,
    input  logic        tx_ready,
    output logic        tx_valid,
    output logic [63:0] tx_data,
    output logic        dac_unf,
    output logic [15:0] unf_count
);

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRIME     = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_UNDERFLOW = 2'd3;

    localparam logic OB_INV = (DATA_FORMAT_OB != 0);

    logic [1:0]  state_reg, state_next;
    logic [63:0] fifo_mem [0:3];
    logic [1:0]  wr_ptr_reg, rd_ptr_reg;
    logic [2:0]  count_reg;
    logic [15:0] ramp_reg;
    logic        tx_valid_reg;
    logic [63:0] tx_data_reg, tx_data_next;
    logic        dac_unf_reg;
    logic [15:0] unf_count_reg;

    logic        fifo_wr, fifo_pop;
    logic [63:0] fifo_head;
    logic [63:0] dma_fmt, dma_word;
    logic [15:0] ramp_s1;
    logic [31:0] ramp_lane;
    logic [63:0] pattern_word, beat_word, beat_masked;
    logic        unf_event, ramp_adv, pn_adv, reseed;

    assign dac_ready = (count_reg != 3'd4);
    assign fifo_wr   = dac_valid & dac_ready;
    assign fifo_pop  = (state_reg == ST_RUN) & tx_ready & (pattern_sel == 2'd0) & (count_reg != 3'd0);
    assign fifo_head = fifo_mem[rd_ptr_reg];

    // Each 16-bit sample is sent high octet first, so the transport mapping is a per-sample byte swap.
    for (genvar gi = 0; gi < 4; gi++) begin : g_dma_sample
        assign dma_fmt[16*gi +: 16]  = {fifo_head[16*gi+15] ^ OB_INV, fifo_head[16*gi +: 15]};
        assign dma_word[16*gi +: 16] = {dma_fmt[16*gi +: 8], dma_fmt[16*gi+8 +: 8]};
    end

    assign ramp_s1   = ramp_reg + 16'd1;
    assign ramp_lane = {ramp_s1[7:0], ramp_s1[15:8], ramp_reg[7:0], ramp_reg[15:8]};

`ifdef DAC_TX_PN_GEN_EN
    logic [14:0] pn_reg, pn_next;
    logic [31:0] pn_bits;
    logic [31:0] pn_lane;

    // Step the x^15+x^14+1 LFSR 32 times per beat; first generated bit lands in pn_bits[31].
    always_comb begin
        pn_next = pn_reg;
        pn_bits = '0;
        for (int i = 0; i < 32; i++) begin
            pn_bits[5'(31 - i)] = pn_next[14];
            pn_next = {pn_next[13:0], pn_next[14] ^ pn_next[13]};
        end
    end

    assign pn_lane = {pn_bits[7:0], pn_bits[15:8], pn_bits[23:16], pn_bits[31:24]};

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            pn_reg <= 15'h7FFF;
        end else if (reseed) begin
            pn_reg <= 15'h7FFF;
        end else if (pn_adv) begin
            pn_reg <= pn_next;
        end
    end
`endif

    always_comb begin
        pattern_word = '0;
        case (pattern_sel)
            2'd2:    pattern_word = {ramp_lane, ramp_lane};
`ifdef DAC_TX_PN_GEN_EN
            2'd3:    pattern_word = {pn_lane, pn_lane};
`endif
            default: pattern_word = '0;
        endcase
    end

    assign beat_word   = (pattern_sel == 2'd0) ? dma_word : pattern_word;
    assign beat_masked = {dac_enable_b ? beat_word[63:32] : 32'd0,
                          dac_enable_a ? beat_word[31:0]  : 32'd0};

    always_comb begin
        state_next   = state_reg;
        tx_data_next = '0;
        unf_event    = 1'b0;
        ramp_adv     = 1'b0;
        pn_adv       = 1'b0;
        reseed       = 1'b0;
        if (!tx_ready) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    state_next = ST_PRIME;
                    reseed     = 1'b1;
                end
                ST_PRIME: begin
                    if (count_reg >= 3'd2 || pattern_sel != 2'd0) begin
                        state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (pattern_sel == 2'd0 && count_reg == 3'd0) begin
                        state_next = ST_UNDERFLOW;
                        unf_event  = 1'b1;
                    end else begin
                        tx_data_next = beat_masked;
                        ramp_adv     = (pattern_sel == 2'd2);
                        pn_adv       = (pattern_sel == 2'd3);
                    end
                end
                default: begin
                    unf_event = 1'b1;
                    if (count_reg >= 3'd2) begin
                        state_next = ST_RUN;
                    end
                end
            endcase
        end
    end

    // FIFO storage is not reset; the pointers define what is valid.
    always_ff @(posedge tx_clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr_reg] <= {dac_data_b, dac_data_a};
        end
    end

    always_ff @(posedge tx_clk or negedge tx_rstn) begin
        if (!tx_rstn) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            ramp_reg      <= '0;
            tx_valid_reg  <= 1'b0;
            tx_data_reg   <= '0;
            dac_unf_reg   <= 1'b0;
            unf_count_reg <= '0;
        end else begin
            state_reg    <= state_next;
            tx_valid_reg <= 1'b1;
            tx_data_reg  <= tx_data_next;
            dac_unf_reg  <= unf_event;
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (fifo_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
            if (reseed) begin
                ramp_reg <= '0;
            end else if (ramp_adv) begin
                ramp_reg <= ramp_reg + 16'd2;
            end
            if (cnt_clr) begin
                unf_count_reg <= '0;
            end else if (unf_event && unf_count_reg != 16'hFFFF) begin
                unf_count_reg <= unf_count_reg + 16'd1;
            end
        end
    end

    assign tx_valid  = tx_valid_reg;
    assign tx_data   = tx_data_reg;
    assign dac_unf   = dac_unf_reg;
    assign unf_count = unf_count_reg;

endmodule
